mem_port_arbiter: RTL and testbench

- Sits between the pipeline's two memory ports and the single physical-memory interface.
- Port A is instruction fetch, read-only; port B is data, read/write. Both are served through one pmem channel, and this block is the responder for both.
- When both ports are outstanding, it returns mem_resp_a and mem_resp_b in the same cycle, because pipeline advance requires the two responses to coincide.
- Read data is buffered so each port sees its rdata stable during its response cycle.

---
 rtl/lc3b_types.sv | 35 +++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory-port arbiter.
//   lc3b_word      : 16-bit data/address word
//   lc3b_mem_wmask : 2-bit byte write mask
//   arb_state_t    : arbiter FSM state encoding
//   pmem_cmd_t     : one physical-memory command (strobes, address, data, mask)
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B,
    RESPOND
  } arb_state_t;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask byte_enable;
  } pmem_cmd_t;

  // Command presented to pmem when nothing is being served.
  localparam pmem_cmd_t PMEM_CMD_NONE = '{
    read:        1'b0,
    write:       1'b0,
    address:     16'h0000,
    wdata:       16'h0000,
    byte_enable: 2'b00
  };

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Funnels the instruction-fetch port (A, read-only) and the data port
// (B, read/write) onto a single physical-memory channel. When both ports
// are outstanding it serves B first, then A, and returns both responses in
// the same cycle so the pipeline can advance on a single event.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read_a, mem_address_a  port A request (held until mem_resp_a)
//   mem_rdata_a, mem_resp_a    port A read data (held between completions), pulse
//   mem_read_b, mem_write_b    port B request strobes (write wins if both high)
//   mem_byte_enable_b          port B write mask
//   mem_address_b, mem_wdata_b port B address / write data
//   mem_rdata_b, mem_resp_b    port B read data (held between completions), pulse
//   pmem_*                     physical-memory request (registered) and response
//   dbg_state                  current FSM state, for observation only
//
// Handshake: a port raises its request and holds it (with address/data
// stable) until it sees its resp pulse; resp is high for exactly one cycle
// and the request must be dropped or replaced by the following rising edge.
// On the pmem side the strobe and its address/data/mask stay stable until
// the cycle in which pmem_resp is sampled high.
module mem_port_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,

  input  logic          mem_read_a,
  input  lc3b_word      mem_address_a,
  output lc3b_word      mem_rdata_a,
  output logic          mem_resp_a,

  input  logic          mem_read_b,
  input  logic          mem_write_b,
  input  lc3b_mem_wmask mem_byte_enable_b,
  input  lc3b_word      mem_address_b,
  input  lc3b_word      mem_wdata_b,
  output lc3b_word      mem_rdata_b,
  output logic          mem_resp_b,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp,

  output arb_state_t    dbg_state
);

  arb_state_t state;
  logic       cap_a, cap_b;
  logic       done_a, done_b;
  lc3b_word   rdata_a, rdata_b;
  logic       resp_a, resp_b;
  pmem_cmd_t  cmd_q;

  logic       req_b;
  logic       late_a, late_b;
  logic       want_a, want_b;
  pmem_cmd_t  cmd_a, cmd_b;

  assign req_b = mem_read_b | mem_write_b;

  // A request that shows up while the other port is being served and has
  // not been captured yet. It is folded into the serve decision in the same
  // cycle, so an arrival coinciding with pmem_resp is still chained.
  assign late_a = mem_read_a & ~cap_a;
  assign late_b = req_b & ~cap_b;
  assign want_a = cap_a | late_a;
  assign want_b = cap_b | late_b;

  // Candidate pmem commands for each port. A write takes precedence over a
  // read on port B; reads always carry a full mask.
  always_comb begin
    cmd_a = '{
      read:        1'b1,
      write:       1'b0,
      address:     mem_address_a,
      wdata:       16'h0000,
      byte_enable: 2'b11
    };
    cmd_b = '{
      read:        1'b1,
      write:       1'b0,
      address:     mem_address_b,
      wdata:       16'h0000,
      byte_enable: 2'b11
    };
    if (mem_write_b) begin
      cmd_b.read        = 1'b0;
      cmd_b.write       = 1'b1;
      cmd_b.wdata       = mem_wdata_b;
      cmd_b.byte_enable = mem_byte_enable_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cap_a   <= 1'b0;
      cap_b   <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      rdata_a <= 16'h0000;
      rdata_b <= 16'h0000;
      resp_a  <= 1'b0;
      resp_b  <= 1'b0;
      cmd_q   <= PMEM_CMD_NONE;
    end else begin
      resp_a <= 1'b0;
      resp_b <= 1'b0;
      unique case (state)
        IDLE: begin
          cap_a <= mem_read_a;
          cap_b <= req_b;
          if (req_b) begin
            state <= SERVE_B;
            cmd_q <= cmd_b;
          end else if (mem_read_a) begin
            state <= SERVE_A;
            cmd_q <= cmd_a;
          end
        end

        SERVE_A: begin
          if (late_b) cap_b <= 1'b1;
          if (pmem_resp) begin
            rdata_a <= pmem_rdata;
            done_a  <= 1'b1;
            if (want_b && !done_b) begin
              state <= SERVE_B;
              cmd_q <= cmd_b;
            end else begin
              // Responses are registered so they land in the RESPOND cycle.
              state  <= RESPOND;
              cmd_q  <= PMEM_CMD_NONE;
              resp_a <= cap_a;
              resp_b <= want_b;
            end
          end
        end

        SERVE_B: begin
          if (late_a) cap_a <= 1'b1;
          if (pmem_resp) begin
            if (!cmd_q.write) rdata_b <= pmem_rdata;
            done_b <= 1'b1;
            if (want_a && !done_a) begin
              state <= SERVE_A;
              cmd_q <= cmd_a;
            end else begin
              state  <= RESPOND;
              cmd_q  <= PMEM_CMD_NONE;
              resp_a <= want_a;
              resp_b <= cap_b;
            end
          end
        end

        RESPOND: begin
          cap_a  <= 1'b0;
          cap_b  <= 1'b0;
          done_a <= 1'b0;
          done_b <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
          cmd_q <= PMEM_CMD_NONE;
        end
      endcase
    end
  end

  assign mem_rdata_a      = rdata_a;
  assign mem_rdata_b      = rdata_b;
  assign mem_resp_a       = resp_a;
  assign mem_resp_b       = resp_b;
  assign pmem_read        = cmd_q.read;
  assign pmem_write       = cmd_q.write;
  assign pmem_address     = cmd_q.address;
  assign pmem_wdata       = cmd_q.wdata;
  assign pmem_byte_enable = cmd_q.byte_enable;
  assign dbg_state        = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a latency-programmable pmem responder,
// a transaction-level model of service order / response timing, and
// per-scenario test tasks.
module tb_mem_port_arbiter;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read_a = 1'b0;
  lc3b_word      mem_address_a = '0;
  lc3b_word      mem_rdata_a;
  logic          mem_resp_a;
  logic          mem_read_b = 1'b0;
  logic          mem_write_b = 1'b0;
  lc3b_mem_wmask mem_byte_enable_b = '0;
  lc3b_word      mem_address_b = '0;
  lc3b_word      mem_wdata_b = '0;
  lc3b_word      mem_rdata_b;
  logic          mem_resp_b;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  arb_state_t    dbg_state;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_rdata_a(mem_rdata_a), .mem_resp_a(mem_resp_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_byte_enable_b(mem_byte_enable_b), .mem_address_b(mem_address_b),
    .mem_wdata_b(mem_wdata_b), .mem_rdata_b(mem_rdata_b), .mem_resp_b(mem_resp_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- pmem responder ----------------
  typedef struct {
    bit          is_b;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    logic [15:0] rdata;
  } acc_t;

  acc_t        log_q[$];   // accesses completed by the responder
  int          lat_q[$];   // latency (extra cycles) for each upcoming access
  logic [15:0] exp_q[$];   // read data to return for each upcoming access
  bit          noise = 1'b0;
  bit          busy = 1'b0;
  int          wait_cnt = 0;
  acc_t        cur;

  always @(negedge clk) begin
    if (noise) begin
      pmem_resp  = 1'($urandom);
      pmem_rdata = 16'($urandom);
      busy = 1'b0;
    end else begin
      pmem_resp = 1'b0;
      if (!(pmem_read || pmem_write)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end
        if (wait_cnt == 0) begin
          cur.is_b  = 1'b0;
          cur.rd    = pmem_read;
          cur.wr    = pmem_write;
          cur.addr  = pmem_address;
          cur.wdata = pmem_wdata;
          cur.mask  = pmem_byte_enable;
          cur.rdata = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
          pmem_rdata = cur.rdata;
          pmem_resp  = 1'b1;
          log_q.push_back(cur);
          busy = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Last data each port should be showing (model state).
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  task automatic clear_inputs();
    mem_read_a = 1'b0; mem_address_a = '0;
    mem_read_b = 1'b0; mem_write_b = 1'b0;
    mem_byte_enable_b = '0; mem_address_b = '0; mem_wdata_b = '0;
  endtask

  // One arbitration round. The model: requests present together are served
  // B first; a B arriving later is served after A. Each access costs lat+1
  // cycles, plus one cycle from request to first strobe; both ports get
  // their response in the same cycle right after the last access.
  task automatic run_txn(input string name, input bit a_en, input logic [15:0] a_addr,
                         input bit b_rd, input bit b_wr, input logic [15:0] b_addr,
                         input logic [15:0] b_wdata, input logic [1:0] b_mask,
                         input int b_delay, input int lat0, input int lat1,
                         input logic [15:0] d0, input logic [15:0] d1);
    acc_t        exp_acc[$];
    acc_t        ea, eb;
    bit          b_en, b_first, got, b_on;
    int          cnt, exp_cnt;
    int          lats[2];
    logic [15:0] dat[2];
    logic [15:0] exp_ra, exp_rb;

    b_en = b_rd | b_wr;
    b_first = b_en && (b_delay == 0);
    lats[0] = lat0; lats[1] = lat1;
    dat[0] = d0; dat[1] = d1;

    ea = '{is_b: 1'b0, rd: 1'b1, wr: 1'b0, addr: a_addr, wdata: '0, mask: 2'b11, rdata: '0};
    eb = '{is_b: 1'b1, rd: !b_wr, wr: b_wr, addr: b_addr,
           wdata: b_wr ? b_wdata : 16'h0, mask: b_wr ? b_mask : 2'b11, rdata: '0};
    if (b_first) exp_acc.push_back(eb);
    if (a_en) exp_acc.push_back(ea);
    if (b_en && !b_first) exp_acc.push_back(eb);

    exp_ra = last_a; exp_rb = last_b; exp_cnt = 1;
    foreach (exp_acc[i]) begin
      exp_acc[i].rdata = dat[i];
      lat_q.push_back(lats[i]);
      exp_q.push_back(dat[i]);
      exp_cnt += lats[i] + 1;
      if (!exp_acc[i].is_b) exp_ra = dat[i];
      else if (exp_acc[i].rd) exp_rb = dat[i];
    end
    log_q.delete();

    @(negedge clk);
    if (a_en) begin mem_read_a = 1'b1; mem_address_a = a_addr; end
    b_on = 1'b0;
    if (b_first) begin
      mem_read_b = b_rd; mem_write_b = b_wr; mem_address_b = b_addr;
      mem_wdata_b = b_wdata; mem_byte_enable_b = b_mask; b_on = 1'b1;
    end
    cnt = 0; got = 1'b0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (b_en && !b_on && cnt == b_delay) begin
        mem_read_b = b_rd; mem_write_b = b_wr; mem_address_b = b_addr;
        mem_wdata_b = b_wdata; mem_byte_enable_b = b_mask; b_on = 1'b1;
      end
      if (mem_resp_a || mem_resp_b) got = 1'b1;
    end

    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no resp within %0d cycles, required at cycle %0d", name, cnt, exp_cnt);
    end else begin
      checks++;
      if (cnt !== exp_cnt) begin
        failures++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, cnt, exp_cnt);
      end
      checks++;
      if ({mem_resp_a, mem_resp_b} !== {a_en, b_en}) begin
        failures++;
        $display("FAIL %s resp_ab: got %b%b, required %b%b", name, mem_resp_a, mem_resp_b, a_en, b_en);
      end
      checks++;
      if (mem_rdata_a !== exp_ra) begin
        failures++;
        $display("FAIL %s rdata_a: got %h, required %h", name, mem_rdata_a, exp_ra);
      end
      checks++;
      if (mem_rdata_b !== exp_rb) begin
        failures++;
        $display("FAIL %s rdata_b: got %h, required %h", name, mem_rdata_b, exp_rb);
      end
    end

    checks++;
    if (log_q.size() !== exp_acc.size()) begin
      failures++;
      $display("FAIL %s access_count: got %0d, required %0d", name, log_q.size(), exp_acc.size());
    end else begin
      foreach (exp_acc[i]) begin
        checks++;
        if (log_q[i].rd !== exp_acc[i].rd || log_q[i].wr !== exp_acc[i].wr ||
            log_q[i].addr !== exp_acc[i].addr || log_q[i].mask !== exp_acc[i].mask ||
            (exp_acc[i].wr && log_q[i].wdata !== exp_acc[i].wdata)) begin
          failures++;
          $display("FAIL %s access%0d: got rd=%b wr=%b addr=%h wdata=%h mask=%b, required rd=%b wr=%b addr=%h wdata=%h mask=%b",
                   name, i, log_q[i].rd, log_q[i].wr, log_q[i].addr, log_q[i].wdata, log_q[i].mask,
                   exp_acc[i].rd, exp_acc[i].wr, exp_acc[i].addr, exp_acc[i].wdata, exp_acc[i].mask);
        end
      end
    end

    clear_inputs();
    @(negedge clk);
    checks++;
    if ({mem_resp_a, mem_resp_b, pmem_read, pmem_write} !== 4'b0000 ||
        mem_rdata_a !== exp_ra || mem_rdata_b !== exp_rb) begin
      failures++;
      $display("FAIL %s after_resp: got resp=%b%b strobes=%b%b rdata=%h/%h, required 00 00 %h/%h",
               name, mem_resp_a, mem_resp_b, pmem_read, pmem_write, mem_rdata_a, mem_rdata_b, exp_ra, exp_rb);
    end
    last_a = exp_ra;
    last_b = exp_rb;
    lat_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    noise = 1'b1;
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      mem_read_a = 1'($urandom); mem_address_a = 16'($urandom);
      mem_read_b = 1'($urandom); mem_write_b = 1'($urandom);
      mem_byte_enable_b = 2'($urandom); mem_address_b = 16'($urandom);
      mem_wdata_b = 16'($urandom);
      #1;
      checks++;
      if ({mem_rdata_a, mem_resp_a, mem_rdata_b, mem_resp_b, pmem_read, pmem_write,
           pmem_address, pmem_wdata, pmem_byte_enable} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got ra=%h respa=%b rb=%h respb=%b rd=%b wr=%b addr=%h wd=%h be=%b, required all 0",
                 mem_rdata_a, mem_resp_a, mem_rdata_b, mem_resp_b, pmem_read, pmem_write,
                 pmem_address, pmem_wdata, pmem_byte_enable);
      end
    end
    @(negedge clk);
    noise = 1'b0;
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got state=%0d strobes=%b%b, required IDLE 00", dbg_state, pmem_read, pmem_write);
    end
    last_a = '0; last_b = '0;
  endtask

  task automatic test_a_only();
    run_txn("a_only", 1'b1, 16'h1000, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 0, 3, 0, 16'hBEEF, 16'h0);
  endtask

  task automatic test_dual();
    run_txn("dual", 1'b1, 16'h2000, 1'b0, 1'b1, 16'h3000, 16'h1234, 2'b01, 0, 1, 2, 16'h1111, 16'hA5A5);
  endtask

  task automatic test_late_arrival();
    run_txn("late_b", 1'b1, 16'h1100, 1'b1, 1'b0, 16'h4000, 16'h0, 2'b00, 2, 3, 1, 16'h2222, 16'h3333);
    run_txn("late_b_edge", 1'b1, 16'h1200, 1'b1, 1'b0, 16'h4100, 16'h0, 2'b00, 1, 0, 0, 16'h4444, 16'h5555);
  endtask

  task automatic test_both_strobes();
    run_txn("rd_wr_both", 1'b0, 16'h0, 1'b1, 1'b1, 16'h5000, 16'hCAFE, 2'b10, 0, 0, 0, 16'h6666, 16'h0);
    run_txn("b_read_min", 1'b0, 16'h0, 1'b1, 1'b0, 16'h5002, 16'h0, 2'b00, 0, 0, 0, 16'h7777, 16'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      bit a_en, b_rd, b_wr;
      int l0, l1, bd;
      a_en = 1'($urandom);
      b_rd = 1'($urandom);
      b_wr = ($urandom_range(0, 3) == 0);
      if (!a_en && !b_rd && !b_wr) a_en = 1'b1;
      l0 = $urandom_range(0, 3);
      l1 = $urandom_range(0, 3);
      bd = 0;
      if (a_en && (b_rd || b_wr) && $urandom_range(0, 1) == 1) bd = $urandom_range(1, 1 + l0);
      run_txn($sformatf("rand%0d", i), a_en, 16'($urandom), b_rd, b_wr, 16'($urandom),
              16'($urandom), 2'($urandom), bd, l0, l1, 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    @(negedge clk);
    lat_q.push_back(20);
    log_q.delete();
    mem_write_b = 1'b1; mem_address_b = 16'h6000; mem_wdata_b = 16'h5555; mem_byte_enable_b = 2'b11;
    n = 0;
    while (!pmem_write && n < 5) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pmem_write !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_strobe: got pmem_write=%b, required 1", pmem_write);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got strobes=%b%b, required 00", pmem_read, pmem_write);
    end
    clear_inputs();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({mem_resp_a, mem_resp_b} !== 2'b00) begin
        failures++;
        $display("FAIL rst_mid_resp: got %b%b, required 00", mem_resp_a, mem_resp_b);
      end
    end
    checks++;
    if (log_q.size() !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_access: got %0d completed accesses, required 0", log_q.size());
    end
    lat_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    last_a = '0; last_b = '0;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL rst_mid_idle: got state=%0d, required IDLE", dbg_state);
    end
    run_txn("after_rst", 1'b1, 16'h7000, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 0, 2, 0, 16'h9999, 16'h0);
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_dual();
    test_late_arrival();
    test_both_strobes();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
